// File: rtl/rldramii_dmaster_st_channel_arb.sv
// -----------------------------------------------------------------------------
// rldramii_dmaster_st_channel_arb
//
// Packet-level round-robin arbiter that merges NUM_IN Avalon-ST byte streams
// onto one registered output stream. Once a requester wins, it keeps the grant
// until its end-of-packet beat is accepted. No other requester can interleave
// beats with the winning packet. The next search then starts at the requester
// after the one that just finished.
//
// Ports
//   clk                 single clock, all state on the rising edge
//   reset_n             synchronous active-low reset
//   port_enable[N]      per-requester enable, looked at only while arbitrating
//   in_valid[N]         per-requester valid
//   in_ready[N]         per-requester ready (combinational)
//   in_data[N*DATA_W]   packed data, requester i at [i*DATA_W +: DATA_W]
//   in_startofpacket[N] per-requester SOP
//   in_endofpacket[N]   per-requester EOP
//   out_valid           registered output valid
//   out_ready           downstream ready
//   out_data            registered output data
//   out_channel         registered index of the granted requester (zero-ext.)
//   out_startofpacket   registered SOP
//   out_endofpacket     registered EOP
//   orphan_err          sticky: a non-SOP beat was discarded while idle
// -----------------------------------------------------------------------------
module rldramii_dmaster_st_channel_arb #(
    parameter int NUM_IN    = 4,
    parameter int DATA_W    = 8,
    parameter int CHANNEL_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_IN-1:0]        port_enable,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_startofpacket,
    input  logic [NUM_IN-1:0]        in_endofpacket,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [CHANNEL_W-1:0]     out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic                     orphan_err
);

    localparam int GW = $clog2(NUM_IN);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Registered state and its next-state values
    state_e               state_q,       state_d;
    logic [GW-1:0]        rr_ptr_q,      rr_ptr_d;
    logic [GW-1:0]        g_q,           g_d;
    logic                 out_valid_q,   out_valid_d;
    logic [DATA_W-1:0]    out_data_q,    out_data_d;
    logic [CHANNEL_W-1:0] out_channel_q, out_channel_d;
    logic                 out_sop_q,     out_sop_d;
    logic                 out_eop_q,     out_eop_d;
    logic                 orphan_err_q,  orphan_err_d;

    // Combinational helpers
    logic [NUM_IN-1:0]    req_s;
    logic [NUM_IN-1:0]    req_rot_s;
    logic                 grant_found_s;
    logic [GW-1:0]        grant_idx_s;
    logic [NUM_IN-1:0]    ready_s;
    logic                 accept_s;
    logic                 g_valid_s;
    logic                 g_sop_s;
    logic                 g_eop_s;
    logic [DATA_W-1:0]    g_data_s;

    // (base + off) mod NUM_IN; both operands are below NUM_IN, so one
    // conditional subtraction is enough even for non power-of-two NUM_IN.
    function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base,
                                               input logic [GW:0]   off);
        logic [GW:0] sum;
        sum = {1'b0, base} + off;
        if (sum >= (GW+1)'(NUM_IN)) begin
            sum = sum - (GW+1)'(NUM_IN);
        end else begin
            sum = sum;
        end
        return GW'(sum);
    endfunction

    // Round-robin search: rotate the request vector so rr_ptr sits at bit 0,
    // then take the lowest set bit. The loop runs downward so the lowest
    // set bit is the last one written.
    always_comb begin
        req_s         = in_valid & in_startofpacket & port_enable;
        req_rot_s     = NUM_IN'({req_s, req_s} >> rr_ptr_q);
        grant_found_s = 1'b0;
        grant_idx_s   = {GW{1'b0}};
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (req_rot_s[k]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = wrap_add(rr_ptr_q, (GW+1)'(k));
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Select the beat currently presented by the granted requester
    always_comb begin
        g_valid_s = 1'b0;
        g_sop_s   = 1'b0;
        g_eop_s   = 1'b0;
        g_data_s  = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_IN; i++) begin
            if (g_q == GW'(i)) begin
                g_valid_s = in_valid[i];
                g_sop_s   = in_startofpacket[i];
                g_eop_s   = in_endofpacket[i];
                g_data_s  = in_data[i*DATA_W +: DATA_W];
            end else begin
                g_valid_s = g_valid_s;
            end
        end
    end

    // Next-state, handshake and output-register load logic
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        g_d           = g_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        orphan_err_d  = orphan_err_q;
        ready_s       = {NUM_IN{1'b0}};
        accept_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // SOP beats are held (ready low) until their grant.
                // Non-SOP beats have no packet to belong to, so they
                // are swallowed and flagged.
                ready_s = in_valid & ~in_startofpacket;
                if (|(in_valid & ~in_startofpacket)) begin
                    orphan_err_d = 1'b1;
                end else begin
                    orphan_err_d = orphan_err_q;
                end
                if (grant_found_s) begin
                    state_d = ST_BUSY;
                    g_d     = grant_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
                // Let a trailing EOP beat drain downstream
                if (out_ready) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            ST_BUSY: begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (g_q == GW'(i)) begin
                        ready_s[i] = out_ready | ~out_valid_q;
                    end else begin
                        ready_s[i] = 1'b0;
                    end
                end
                accept_s = g_valid_s & (out_ready | ~out_valid_q);
                if (accept_s) begin
                    out_valid_d   = 1'b1;
                    out_data_d    = g_data_s;
                    out_channel_d = CHANNEL_W'(g_q);
                    out_sop_d     = g_sop_s;
                    out_eop_d     = g_eop_s;
                    if (g_eop_s) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = wrap_add(g_q, (GW+1)'(1));
                    end else begin
                        state_d  = ST_BUSY;
                    end
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= {GW{1'b0}};
            g_q           <= {GW{1'b0}};
            out_valid_q   <= 1'b0;
            out_data_q    <= {DATA_W{1'b0}};
            out_channel_q <= {CHANNEL_W{1'b0}};
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            orphan_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            g_q           <= g_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            orphan_err_q  <= orphan_err_d;
        end
    end

    // in_ready is forced low while reset is asserted
    assign in_ready          = ready_s & {NUM_IN{reset_n}};
    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign out_channel       = out_channel_q;
    assign out_startofpacket = out_sop_q;
    assign out_endofpacket   = out_eop_q;
    assign orphan_err        = orphan_err_q;

endmodule
